// File: rtl/udp_cmd_transfer_ctrl_if.sv
// ---------------------------------------------------------------------------
// udp_cmd_transfer_ctrl_if
//   UDP RX bus as seen by the command decoder. The udp_rx block is the master.
//   udp_rec_pkt_done  : packet receive complete, 1-cycle pulse
//   udp_rec_en        : udp_rec_data valid
//   udp_rec_data      : received word, byte0 in [31:24], byte1 in [23:16]
//   udp_rec_byte_num  : payload byte count, valid with udp_rec_pkt_done
// ---------------------------------------------------------------------------
interface udp_cmd_transfer_ctrl_if;
  logic        udp_rec_pkt_done;
  logic        udp_rec_en;
  logic [31:0] udp_rec_data;
  logic [15:0] udp_rec_byte_num;

  modport master (
    output udp_rec_pkt_done,
    output udp_rec_en,
    output udp_rec_data,
    output udp_rec_byte_num
  );

  modport slave (
    input  udp_rec_pkt_done,
    input  udp_rec_en,
    input  udp_rec_data,
    input  udp_rec_byte_num
  );
endinterface

// File: rtl/udp_cmd_transfer_ctrl.sv
// ---------------------------------------------------------------------------
// udp_cmd_transfer_ctrl
//   Decodes short ASCII command packets from udp_rx and drives per-channel
//   transfer enables. Supports per-channel start/stop/keepalive, a 1-byte
//   broadcast start/stop, ack/err pulses and an optional per-channel watchdog
//   that stops a channel when keepalives stop arriving.
// Ports
//   clk           : system clock (UDP RX domain)
//   rst           : synchronous reset, active-high
//   rx            : UDP RX bus (slave side)
//   transfer_flag : per-channel transfer enable
//   timeout_flag  : sticky per-channel watchdog-expired status
//   cmd_ack       : 1-cycle pulse, valid command applied
//   cmd_err       : 1-cycle pulse, packet rejected, no state change
// Timing: pkt_done in cycle N -> outputs change / pulse in cycle N+2.
// ---------------------------------------------------------------------------
module udp_cmd_transfer_ctrl #(
  parameter int          NUM_CH      = 4,
  parameter logic [31:0] TIMEOUT_CYC = 32'd0,
  parameter logic [7:0]  OP_START    = "1",
  parameter logic [7:0]  OP_STOP     = "0",
  parameter logic [7:0]  OP_KEEP     = "K"
) (
  input  logic                         clk,
  input  logic                         rst,
  udp_cmd_transfer_ctrl_if.slave       rx,
  output logic [NUM_CH-1:0]            transfer_flag,
  output logic [NUM_CH-1:0]            timeout_flag,
  output logic                         cmd_ack,
  output logic                         cmd_err
);

  localparam bit WDOG_EN = (TIMEOUT_CYC != 32'd0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_EXEC = 2'd2
  } state_t;

  state_t                    state_q;
  logic [7:0]                b0_q, b1_q;
  logic [15:0]               bn_q;
  logic                      noword_q;     // pkt_done seen without any data word
  logic [NUM_CH-1:0]         flag_q, tmo_q;
  logic [NUM_CH-1:0][31:0]   wdog_q;
  logic                      ack_q, err_q;

  // Only the first two payload bytes carry a command.
  logic unused_data;
  assign unused_data = ^rx.udp_rec_data[15:0];

  // ---------------- command decode (valid while in S_EXEC) ----------------
  logic [7:0]        ch_d;
  logic              dec_err_d;
  logic [NUM_CH-1:0] set_d, clr_d, rld_d;

  always_comb begin
    ch_d      = b1_q - 8'h30;     // chars below '0' wrap high and are rejected
    dec_err_d = 1'b0;
    set_d     = '0;
    clr_d     = '0;
    rld_d     = '0;
    if (noword_q) begin
      dec_err_d = 1'b1;
    end else if (bn_q == 16'd1) begin
      if (b0_q == OP_START) begin
        set_d = '1;
        rld_d = '1;
      end else if (b0_q == OP_STOP) begin
        clr_d = '1;
      end else begin
        dec_err_d = 1'b1;
      end
    end else if (bn_q == 16'd2) begin
      if (ch_d >= 8'(NUM_CH)) begin
        dec_err_d = 1'b1;
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (ch_d == 8'(i)) begin
            if (b0_q == OP_START) begin
              set_d[i] = 1'b1;
              rld_d[i] = 1'b1;
            end else if (b0_q == OP_STOP) begin
              clr_d[i] = 1'b1;
            end else if (b0_q == OP_KEEP) begin
              // keepalive on a stopped channel is a protocol error
              if (flag_q[i]) rld_d[i] = 1'b1;
              else           dec_err_d = 1'b1;
            end else begin
              dec_err_d = 1'b1;
            end
          end
        end
      end
    end else begin
      dec_err_d = 1'b1;
    end
  end

  logic              cmd_go_d;
  logic [NUM_CH-1:0] touch_d;
  assign cmd_go_d = (state_q == S_EXEC) && !dec_err_d;
  assign touch_d  = cmd_go_d ? (set_d | clr_d | rld_d) : '0;

  // ---------------- FSM, channel state, watchdogs ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      b0_q     <= '0;
      b1_q     <= '0;
      bn_q     <= '0;
      noword_q <= 1'b0;
      flag_q   <= '0;
      tmo_q    <= '0;
      wdog_q   <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;

      // Per channel: a command touching the channel wins over watchdog
      // expiry in the same cycle, so the watchdog step is skipped there.
      for (int i = 0; i < NUM_CH; i++) begin
        if (touch_d[i]) begin
          if (set_d[i]) begin
            flag_q[i] <= 1'b1;
            tmo_q[i]  <= 1'b0;
          end
          if (clr_d[i]) flag_q[i] <= 1'b0;
          if (rld_d[i]) wdog_q[i] <= TIMEOUT_CYC;
        end else if (WDOG_EN && flag_q[i] && (wdog_q[i] != 32'd0)) begin
          wdog_q[i] <= wdog_q[i] - 32'd1;
          if (wdog_q[i] == 32'd1) begin
            flag_q[i] <= 1'b0;
            tmo_q[i]  <= 1'b1;
          end
        end
      end

      case (state_q)
        S_IDLE: begin
          if (rx.udp_rec_en) begin
            b0_q     <= rx.udp_rec_data[31:24];
            b1_q     <= rx.udp_rec_data[23:16];
            noword_q <= 1'b0;
            if (rx.udp_rec_pkt_done) begin
              bn_q    <= rx.udp_rec_byte_num;
              state_q <= S_EXEC;
            end else begin
              state_q <= S_RECV;
            end
          end else if (rx.udp_rec_pkt_done) begin
            bn_q     <= rx.udp_rec_byte_num;
            noword_q <= 1'b1;
            state_q  <= S_EXEC;
          end
        end
        S_RECV: begin
          // later data words carry nothing we decode
          if (rx.udp_rec_pkt_done) begin
            bn_q    <= rx.udp_rec_byte_num;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          ack_q   <= !dec_err_d;
          err_q   <= dec_err_d;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign transfer_flag = flag_q;
  assign timeout_flag  = tmo_q;
  assign cmd_ack       = ack_q;
  assign cmd_err       = err_q;

endmodule

// File: tb/tb_udp_cmd_transfer_ctrl.sv
module tb_udp_cmd_transfer_ctrl;
  localparam int NUM_CH = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NUM_CH-1:0] transfer_flag, timeout_flag;
  logic              cmd_ack, cmd_err;
  int                checks = 0;
  int                errors = 0;

  udp_cmd_transfer_ctrl_if rx();

  udp_cmd_transfer_ctrl #(
    .NUM_CH     (NUM_CH),
    .TIMEOUT_CYC(32'd100)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx.slave),
    .transfer_flag(transfer_flag),
    .timeout_flag (timeout_flag),
    .cmd_ack      (cmd_ack),
    .cmd_err      (cmd_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout sim did not finish");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rx.udp_rec_en = 1'b0; rx.udp_rec_pkt_done = 1'b0;
    rx.udp_rec_data = '0; rx.udp_rec_byte_num = '0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  // Send one packet, then check latency, the N+2 result and that the pulse
  // is a single cycle. Ends in cycle N+5.
  task automatic cmd(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                     input logic [15:0] n, input bit one_cyc,
                     input logic [3:0] ef, input logic [3:0] et, input bit ea, input bit ee);
    rx.udp_rec_data = {b0, b1, 16'h0};
    rx.udp_rec_en   = 1'b1;
    if (one_cyc) begin
      rx.udp_rec_pkt_done = 1'b1; rx.udp_rec_byte_num = n;
    end else begin
      tick();
      rx.udp_rec_en = 1'b0;
      rx.udp_rec_pkt_done = 1'b1; rx.udp_rec_byte_num = n;
    end
    tick();                                  // now N+1
    rx.udp_rec_en = 1'b0; rx.udp_rec_pkt_done = 1'b0;
    chk({tag, "_n1_ack"}, 32'(cmd_ack), 32'd0);
    chk({tag, "_n1_err"}, 32'(cmd_err), 32'd0);
    tick();                                  // N+2
    chk({tag, "_flag"}, 32'(transfer_flag), 32'(ef));
    chk({tag, "_tmo"},  32'(timeout_flag),  32'(et));
    chk({tag, "_ack"},  32'(cmd_ack), 32'(ea));
    chk({tag, "_err"},  32'(cmd_err), 32'(ee));
    tick();                                  // N+3
    chk({tag, "_pulse"}, 32'({cmd_ack, cmd_err}), 32'd0);
    tick(); tick();
  endtask

  initial begin
    do_reset();
    chk("rst_flag", 32'(transfer_flag), 32'h0);
    chk("rst_tmo",  32'(timeout_flag),  32'h0);
    chk("rst_pulse", 32'({cmd_ack, cmd_err}), 32'd0);

    // broadcast
    cmd("bc_start", "1", 8'h00, 16'd1, 1'b0, 4'hF, 4'h0, 1'b1, 1'b0);
    cmd("bc_stop",  "0", 8'h00, 16'd1, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
    cmd("bc_badop", "X", 8'h00, 16'd1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1);

    // per-channel
    cmd("ch2_start", "1", "2", 16'd2, 1'b0, 4'b0100, 4'h0, 1'b1, 1'b0);
    cmd("ch2_stop",  "0", "2", 16'd2, 1'b0, 4'b0000, 4'h0, 1'b1, 1'b0);
    cmd("ch3_start", "1", "3", 16'd2, 1'b0, 4'b1000, 4'h0, 1'b1, 1'b0);
    cmd("ch9_bad",   "1", "9", 16'd2, 1'b0, 4'b1000, 4'h0, 1'b0, 1'b1);
    cmd("ch_badop",  "Z", "3", 16'd2, 1'b0, 4'b1000, 4'h0, 1'b0, 1'b1);
    cmd("ch3_again", "1", "3", 16'd2, 1'b0, 4'b1000, 4'h0, 1'b1, 1'b0);

    // pkt_done with no data word, byte_num 0
    rx.udp_rec_pkt_done = 1'b1; rx.udp_rec_byte_num = 16'd0;
    tick();
    rx.udp_rec_pkt_done = 1'b0;
    tick();
    chk("noword_ack", 32'(cmd_ack), 32'd0);
    chk("noword_err", 32'(cmd_err), 32'd1);
    tick(); tick(); tick();

    // watchdog expiry: start applied at N+2, flag drops at N+102
    do_reset();
    cmd("wd_start", "1", "0", 16'd2, 1'b0, 4'b0001, 4'h0, 1'b1, 1'b0);
    repeat (96) tick();                      // N+101
    chk("wd_pre_flag", 32'(transfer_flag), 32'h1);
    chk("wd_pre_tmo",  32'(timeout_flag),  32'h0);
    tick();                                  // N+102
    chk("wd_exp_flag", 32'(transfer_flag), 32'h0);
    chk("wd_exp_tmo",  32'(timeout_flag),  32'h1);
    repeat (10) tick();
    chk("wd_sticky", 32'(timeout_flag), 32'h1);
    // broadcast start clears timeout status
    cmd("wd_bc", "1", 8'h00, 16'd1, 1'b0, 4'hF, 4'h0, 1'b1, 1'b0);

    // keepalive holds the channel up
    do_reset();
    cmd("ka_start", "1", "0", 16'd2, 1'b0, 4'b0001, 4'h0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      repeat (74) tick();
      cmd("ka_k0", "K", "0", 16'd2, 1'b0, 4'b0001, 4'h0, 1'b1, 1'b0);
    end
    cmd("ka_k1", "K", "1", 16'd2, 1'b0, 4'b0001, 4'h0, 1'b0, 1'b1);

    // single-word packets, en and pkt_done together
    do_reset();
    cmd("sw_ch3", "1", "3", 16'd2, 1'b1, 4'b1000, 4'h0, 1'b1, 1'b0);
    cmd("sw_bn3", "1", "1", 16'd3, 1'b1, 4'b1000, 4'h0, 1'b0, 1'b1);

    // reset mid-packet discards it
    cmd("mr_bc", "1", 8'h00, 16'd1, 1'b0, 4'hF, 4'h0, 1'b1, 1'b0);
    rx.udp_rec_data = {8'h31, 8'h31, 16'h0};
    rx.udp_rec_en = 1'b1;
    tick();
    rx.udp_rec_en = 1'b0;
    rst = 1'b1;
    tick();
    rx.udp_rec_pkt_done = 1'b1; rx.udp_rec_byte_num = 16'd2;
    tick();
    rx.udp_rec_pkt_done = 1'b0;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("mr_flag",  32'(transfer_flag), 32'h0);
      chk("mr_tmo",   32'(timeout_flag),  32'h0);
      chk("mr_pulse", 32'({cmd_ack, cmd_err}), 32'd0);
    end
    cmd("mr_after", "1", "1", 16'd2, 1'b0, 4'b0010, 4'h0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
